serial_add_sub_unit: RTL

- Multi-cycle, bit-serial WIDTH-bit adder/subtractor for area-constrained ALU paths.
- Feeds a single combinational 1-bit full-adder cell one operand bit pair plus a registered carry each cycle, LSB first.
- Consumes the cell's sum/carry: the sum shifts into the result register and the carry is registered for the next bit.
- Provides a start/ready/valid handshake and the carry, overflow and zero flags for branch/ALU logic.

---
 rtl/serial_add_sub_unit.sv | 82 ++++++++
 1 files changed

// File: rtl/serial_add_sub_unit.sv
// serial_add_sub_unit: bit-serial WIDTH-bit adder/subtractor, one bit per cycle LSB first,
// with start/ready/valid handshake and carry/overflow/zero flags.
module serial_add_sub_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, work, work_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, sum, cout, last;

    assign sum      = op_a[0] ^ op_b[0] ^ carry;
    assign cout     = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
    assign work_nxt = {sum, work[WIDTH-1:1]};
    assign last     = (state == RUN) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE && start_i) ? RUN :
                    last                       ? DONE :
                    (state == DONE)            ? IDLE : state;
    end

    always_comb begin
        ready_o = (state == IDLE);
        valid_o = (state == DONE);
    end

    // Subtraction is A + ~B + 1: invert B and seed the carry with sub_i at accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_a       <= '0;
            op_b       <= '0;
            work       <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            result_o   <= '0;
            carry_o    <= 1'b0;
            overflow_o <= 1'b0;
            zero_o     <= 1'b0;
        end else if (state == IDLE && start_i) begin
            op_a  <= a_i;
            op_b  <= b_i ^ {WIDTH{sub_i}};
            carry <= sub_i;
            cnt   <= '0;
            work  <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= cout;
            cnt   <= cnt + CW'(1);
            work  <= work_nxt;
            if (last) begin
                // On the MSB step the carry flop holds the carry into the MSB.
                result_o   <= work_nxt;
                carry_o    <= cout;
                overflow_o <= carry ^ cout;
                zero_o     <= (work_nxt == '0);
            end
        end
    end
endmodule
